// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, timing defaults and colour reordering for the LED frame scheduler
package led_pkg;

    localparam int CLK_NS   = 20;
    localparam int LATCH_NS = 60000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DRAIN,
        ST_LATCH
    } state_t;

    // WS2812 shifts green first, then red, then blue.
    function automatic logic [23:0] grb_order(input pixel_t p);
        return {p.g, p.r, p.b};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts just after ptr
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - grants the strip per frame, streams pixels to the encoder, enforces latch gap
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int LENGTH       = 10,
    parameter int NUM_SRC      = 2,
    parameter int LATCH_CYCLES = LATCH_NS / CLK_NS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          frame_req,
    output logic [NUM_SRC-1:0]          frame_gnt,
    output logic                        frame_done,
    output logic [$clog2(LENGTH)-1:0]   src_addr,
    output logic                        src_rd,
    input  logic [NUM_SRC*24-1:0]       src_data,
    output logic [23:0]                 pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    input  logic                        enc_idle,
    output logic                        busy
);

    localparam int AW = $clog2(LENGTH);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH - 1);

    state_t             state;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      rr_ptr;
    logic [AW-1:0]      pix_idx;
    logic [CW-1:0]      latch_cnt;
    logic [23:0]        sel_word;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req (frame_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    // The grant is one-hot, so it doubles as the read-data mux select.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (frame_gnt[i]) sel_word = src_data[i*24 +: 24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frame_gnt  <= '0;
            frame_done <= 1'b0;
            src_addr   <= '0;
            src_rd     <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            gnt_idx    <= '0;
            rr_ptr     <= PW'(NUM_SRC - 1);
            pix_idx    <= '0;
            latch_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|frame_req) begin
                        frame_gnt <= arb_gnt;
                        gnt_idx   <= arb_idx;
                        pix_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    src_addr <= pix_idx;
                    src_rd   <= 1'b1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    src_rd    <= 1'b0;
                    pix_data  <= grb_order(pixel_t'(sel_word));
                    pix_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            pix_idx <= pix_idx + 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (enc_idle) begin
                        latch_cnt <= CW'(LATCH_CYCLES - 1);
                        state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    // Counting down to zero inclusive gives exactly LATCH_CYCLES cycles here.
                    if (latch_cnt == '0) begin
                        frame_done <= 1'b1;
                        frame_gnt  <= '0;
                        rr_ptr     <= gnt_idx;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - scoreboard bench for led_frame_scheduler
module tb_led_frame_scheduler;

    localparam int LENGTH       = 6;
    localparam int NUM_SRC      = 2;
    localparam int LATCH_CYCLES = 3000;
    localparam int AW           = $clog2(LENGTH);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_SRC-1:0]      frame_req = '0;
    logic [NUM_SRC-1:0]      frame_gnt;
    logic                    frame_done;
    logic [AW-1:0]           src_addr;
    logic                    src_rd;
    logic [NUM_SRC*24-1:0]   src_data;
    logic [23:0]             pix_data;
    logic                    pix_valid;
    logic                    pix_ready = 1'b1;
    logic                    enc_idle = 1'b1;
    logic                    busy;

    logic [23:0] mem0 [LENGTH] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF, 24'h010203};
    logic [23:0] mem1 [LENGTH] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0, 24'hD0E0F0, 24'h0A0B0C};
    logic [23:0] exp0 [LENGTH] = '{24'h221133, 24'h554466, 24'h887799, 24'hBBAACC, 24'hEEDDFF, 24'h020103};
    logic [23:0] exp1 [LENGTH] = '{24'h201030, 24'h504060, 24'h807090, 24'hB0A0C0, 24'hE0D0F0, 24'h0B0A0C};

    int n_checks = 0;
    int n_fail   = 0;

    logic [NUM_SRC+23:0] exp_pix [$];
    logic [NUM_SRC-1:0]  exp_done [$];

    led_frame_scheduler #(
        .LENGTH       (LENGTH),
        .NUM_SRC      (NUM_SRC),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_req  (frame_req),
        .frame_gnt  (frame_gnt),
        .frame_done (frame_done),
        .src_addr   (src_addr),
        .src_rd     (src_rd),
        .src_data   (src_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .enc_idle   (enc_idle),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    always_comb begin
        src_data = '0;
        if (int'(src_addr) < LENGTH) src_data = {mem1[src_addr], mem0[src_addr]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input int src, input int npix);
        for (int i = 0; i < npix; i++)
            exp_pix.push_back({NUM_SRC'(1 << src), (src == 0) ? exp0[i] : exp1[i]});
        if (npix == LENGTH) exp_done.push_back(NUM_SRC'(1 << src));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [NUM_SRC-1:0] exp);
        for (int i = 0; i < 20 && frame_gnt == '0; i++) step();
        check("grant", frame_gnt, exp);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", seen, 1);
    endtask

    task automatic wait_rd_addr(input int addr);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (src_rd && int'(src_addr) == addr) seen = 1'b1;
        end
        check("rd_addr_seen", seen, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},   frame_gnt, 0);
        check({tag, "_done"},  frame_done, 0);
        check({tag, "_addr"},  src_addr, 0);
        check({tag, "_rd"},    src_rd, 0);
        check({tag, "_data"},  pix_data, 0);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // Monitor: samples on the falling edge, where inputs driven after the rising edge are stable.
    logic [NUM_SRC-1:0] last_gnt = '0;
    bit                 prev_stall = 1'b0;
    logic [23:0]        prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_onehot", 32'($onehot0(frame_gnt)), 1);
            if (frame_gnt != '0) last_gnt = frame_gnt;
            if (prev_stall) begin
                check("valid_hold", pix_valid, 1);
                check("data_hold", pix_data, prev_data);
            end
            if (pix_valid && pix_ready) begin
                if (exp_pix.size() == 0) check("pix_unexpected", pix_data, 0);
                else check("pix_word", {frame_gnt, pix_data}, exp_pix.pop_front());
            end
            if (frame_done) begin
                if (exp_done.size() == 0) check("done_unexpected", frame_done, 0);
                else check("done_src", last_gnt, exp_done.pop_front());
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #(100000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd_cnt;
        bit seen;

        repeat (3) step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Single source: grant latency, then the full frame.
        expect_frame(0, LENGTH);
        frame_req = 2'b01;
        step();
        check("lat_gnt", frame_gnt, 2'b01);
        check("lat_busy", busy, 1);
        check("lat_rd_early", src_rd, 0);
        step();
        check("lat_rd", src_rd, 1);
        check("lat_addr", src_addr, 0);
        frame_req = 2'b00;
        wait_done();

        // Both request continuously: pointer now at 0, so 1,0,1,0.
        expect_frame(1, LENGTH);
        expect_frame(0, LENGTH);
        expect_frame(1, LENGTH);
        expect_frame(0, LENGTH);
        frame_req = 2'b11;
        repeat (4) wait_done();
        frame_req = 2'b00;

        // Backpressure on pixel 1.
        expect_frame(0, LENGTH);
        frame_req = 2'b01;
        wait_gnt(2'b01);
        frame_req = 2'b00;
        wait_rd_addr(1);
        pix_ready = 1'b0;
        rd_cnt = 0;
        repeat (50) begin
            step();
            if (src_rd) rd_cnt++;
        end
        check("bp_no_rd", rd_cnt, 0);
        check("bp_valid", pix_valid, 1);
        check("bp_data", pix_data, 24'h554466);
        pix_ready = 1'b1;
        wait_done();

        // Latch timing with a slow encoder.
        expect_frame(1, LENGTH);
        enc_idle = 1'b0;
        frame_req = 2'b10;
        wait_gnt(2'b10);
        frame_req = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (pix_valid && pix_ready && int'(src_addr) == LENGTH - 1) seen = 1'b1;
        end
        check("last_hs_seen", seen, 1);
        repeat (100) step();
        check("drain_busy", busy, 1);
        enc_idle = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            step();
            n++;
            if (frame_done) seen = 1'b1;
        end
        check("latch_cycles", n - 1, LATCH_CYCLES);

        // Requester swap mid-frame: source 1 completes, then source 0.
        expect_frame(1, LENGTH);
        expect_frame(0, LENGTH);
        frame_req = 2'b10;
        wait_gnt(2'b10);
        wait_rd_addr(3);
        frame_req = 2'b01;
        wait_done();
        wait_done();
        frame_req = 2'b00;

        // Reset in SEND at pixel 5: pixels 0..4 go out, no frame_done.
        expect_frame(0, LENGTH - 1);
        frame_req = 2'b01;
        wait_gnt(2'b01);
        frame_req = 2'b00;
        wait_rd_addr(5);
        pix_ready = 1'b0;
        step();
        check("pre_rst_valid", pix_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (5) step();
        rst_n = 1'b1;
        pix_ready = 1'b1;
        expect_frame(1, LENGTH);
        frame_req = 2'b10;
        step();
        check("post_rst_gnt", frame_gnt, 2'b10);
        step();
        check("post_rst_rd", src_rd, 1);
        check("post_rst_addr", src_addr, 0);
        frame_req = 2'b00;
        wait_done();

        repeat (5) step();
        check("pix_queue_empty", exp_pix.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
